poly_root_finder: RTL and testbench
===================================

POLY_ROOT_FINDER -- requirements
Module: poly_root_finder

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on posedge.
REQ-002 SHALL have port: resetn  input  1  reset; asynchronous and active-low.
REQ-003 SHALL have port: go  input  1  active-high load/acknowledge strobe; press-and-release handshake.
REQ-004 SHALL have port: data_in  input  8  operand value sampled in load states.
REQ-005 SHALL have port: data_result  output  8  registered root x; 0 when none found.
REQ-006 SHALL have port: found  output  1  registered; 1 = data_result is a valid root.
REQ-007 SHALL have port: done  output  1  high while in DONE or DONE_WAIT.
REQ-008 SHALL have port: busy  output  1  high while in EVAL_0..EVAL_3.

Function
REQ-009 SHALL find the smallest x in 0..255 with A*x*x + B*x + C == Y, all arithmetic mod 256 (8-bit truncation at every step).
REQ-010 SHALL use states LOAD_A, LOAD_A_WAIT, LOAD_B, LOAD_B_WAIT, LOAD_C, LOAD_C_WAIT, LOAD_Y, LOAD_Y_WAIT, EVAL_0, EVAL_1, EVAL_2, EVAL_3, DONE, DONE_WAIT.
REQ-011 SHALL, in LOAD_k, load register k from data_in every cycle; go=1 -> LOAD_k_WAIT, else stay.
REQ-012 SHALL, in LOAD_k_WAIT, hold register k; go=0 -> next LOAD state (A->B->C->Y); LOAD_Y_WAIT with go=0 -> EVAL_0.
REQ-013 SHALL, on the LOAD_Y_WAIT -> EVAL_0 transition, clear x, t, found and data_result to 0.
REQ-014 SHALL evaluate by Horner with one shared 8-bit add/multiply ALU: EVAL_0 t<=A*x; EVAL_1 t<=t+B; EVAL_2 t<=t*x; EVAL_3 compare (t+C) to Y combinationally.
REQ-015 SHALL, in EVAL_3 on match: data_result<=x, found<=1, next DONE.
REQ-016 SHALL, in EVAL_3 on mismatch with x==255: data_result<=0, found<=0, next DONE.
REQ-017 SHALL, in EVAL_3 on mismatch with x<255: x<=x+1, next EVAL_0.
REQ-018 SHALL take exactly 4 cycles per candidate; root x reported in DONE 4*(x+1) cycles after entering EVAL_0; no-root case 1024 cycles.
REQ-019 SHALL ignore go during EVAL_0..EVAL_3.
REQ-020 SHALL, in DONE, hold data_result/found; go=1 -> DONE_WAIT; DONE_WAIT with go=0 -> LOAD_A.
REQ-021 SHALL retain data_result/found through LOAD_A..LOAD_Y_WAIT of the next search until REQ-013 clears them.
REQ-022 SHALL keep A, B, C, Y unchanged outside their own LOAD state.
REQ-023 SHALL drive done and busy combinationally from current state only.

Reset
REQ-024 SHALL, on resetn=0 at any time, immediately force state LOAD_A and A, B, C, Y, x, t, data_result, found to 0, independent of clk.
REQ-025 SHALL hold that state while resetn=0; outputs after reset: data_result=0, found=0, done=0, busy=0.
REQ-026 SHALL abandon any in-progress search on reset; no partial result retained.

Verification
REQ-027 SHALL check A=1,B=0,C=0,Y=9 -> found=1, data_result=3, done 16 cycles after EVAL_0 entry.
REQ-028 SHALL check A=0,B=0,C=5,Y=5 -> found=1, data_result=0 after 4 cycles.
REQ-029 SHALL check wrap-around A=0,B=1,C=10,Y=4 -> found=1, data_result=250 (0xFA).
REQ-030 SHALL check A=0,B=0,C=5,Y=6 -> found=0, data_result=0, done after exactly 1024 cycles.
REQ-031 SHALL check A=2,B=3,C=1,Y=15 with go held high throughout EVAL -> data_result=2, found=1, no state disturbance; then go press/release returns to LOAD_A.
REQ-032 SHALL check resetn pulsed low mid-EVAL (no clk edge) -> immediate LOAD_A, all outputs 0; subsequent full search correct.

Source files
------------

// File: rtl/poly_root_finder.sv
// Brute-force root search for A*x^2 + B*x + C == Y (mod 256), smallest x first.
// Operands are loaded one at a time with a press/release go handshake; Horner evaluation uses one shared ALU.
module poly_root_finder (
   input  logic       clk,
   input  logic       resetn,
   input  logic       go,
   input  logic [7:0] data_in,
   output logic [7:0] data_result,
   output logic       found,
   output logic       done,
   output logic       busy,
   output logic [3:0] dbg_state
);

   typedef enum logic [3:0] {
      LOAD_A      = 4'd0,
      LOAD_A_WAIT = 4'd1,
      LOAD_B      = 4'd2,
      LOAD_B_WAIT = 4'd3,
      LOAD_C      = 4'd4,
      LOAD_C_WAIT = 4'd5,
      LOAD_Y      = 4'd6,
      LOAD_Y_WAIT = 4'd7,
      EVAL_0      = 4'd8,
      EVAL_1      = 4'd9,
      EVAL_2      = 4'd10,
      EVAL_3      = 4'd11,
      DONE        = 4'd12,
      DONE_WAIT   = 4'd13
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] a_q, a_d, b_q, b_d, c_q, c_d, y_q, y_d;
   logic [7:0] x_q, x_d, t_q, t_d;
   logic [7:0] result_q, result_d;
   logic       found_q, found_d;

   logic [7:0]  alu_a, alu_b, alu_y, alu_sum;
   logic        alu_mul;
   logic [15:0] alu_prod;
   logic        match;

   // Shared ALU: operands and operation chosen by the evaluation step.
   always_comb begin
      alu_a   = t_q;
      alu_b   = b_q;
      alu_mul = 1'b0;
      case (state_q)
         EVAL_0: begin alu_a = a_q; alu_b = x_q; alu_mul = 1'b1; end
         EVAL_1: begin alu_a = t_q; alu_b = b_q; alu_mul = 1'b0; end
         EVAL_2: begin alu_a = t_q; alu_b = x_q; alu_mul = 1'b1; end
         EVAL_3: begin alu_a = t_q; alu_b = c_q; alu_mul = 1'b0; end
         default: ;
      endcase
      alu_prod = {8'd0, alu_a} * {8'd0, alu_b};
      alu_sum  = alu_a + alu_b;
      alu_y    = alu_mul ? alu_prod[7:0] : alu_sum;
      match    = (alu_y == y_q);
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      y_d      = y_q;
      x_d      = x_q;
      t_d      = t_q;
      result_d = result_q;
      found_d  = found_q;
      case (state_q)
         LOAD_A: begin
            a_d = data_in;
            if (go) state_d = LOAD_A_WAIT;
         end
         LOAD_A_WAIT: if (!go) state_d = LOAD_B;
         LOAD_B: begin
            b_d = data_in;
            if (go) state_d = LOAD_B_WAIT;
         end
         LOAD_B_WAIT: if (!go) state_d = LOAD_C;
         LOAD_C: begin
            c_d = data_in;
            if (go) state_d = LOAD_C_WAIT;
         end
         LOAD_C_WAIT: if (!go) state_d = LOAD_Y;
         LOAD_Y: begin
            y_d = data_in;
            if (go) state_d = LOAD_Y_WAIT;
         end
         LOAD_Y_WAIT: begin
            if (!go) begin
               state_d  = EVAL_0;
               x_d      = 8'd0;
               t_d      = 8'd0;
               result_d = 8'd0;
               found_d  = 1'b0;
            end
         end
         EVAL_0: begin t_d = alu_y; state_d = EVAL_1; end
         EVAL_1: begin t_d = alu_y; state_d = EVAL_2; end
         EVAL_2: begin t_d = alu_y; state_d = EVAL_3; end
         EVAL_3: begin
            if (match) begin
               result_d = x_q;
               found_d  = 1'b1;
               state_d  = DONE;
            end else if (x_q == 8'd255) begin
               result_d = 8'd0;
               found_d  = 1'b0;
               state_d  = DONE;
            end else begin
               x_d     = x_q + 8'd1;
               state_d = EVAL_0;
            end
         end
         DONE:      if (go)  state_d = DONE_WAIT;
         DONE_WAIT: if (!go) state_d = LOAD_A;
         default:   state_d = LOAD_A;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= LOAD_A;
         a_q      <= 8'd0;
         b_q      <= 8'd0;
         c_q      <= 8'd0;
         y_q      <= 8'd0;
         x_q      <= 8'd0;
         t_q      <= 8'd0;
         result_q <= 8'd0;
         found_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         y_q      <= y_d;
         x_q      <= x_d;
         t_q      <= t_d;
         result_q <= result_d;
         found_q  <= found_d;
      end
   end

   assign data_result = result_q;
   assign found       = found_q;
   assign done        = (state_q == DONE) || (state_q == DONE_WAIT);
   assign busy        = (state_q == EVAL_0) || (state_q == EVAL_1) ||
                        (state_q == EVAL_2) || (state_q == EVAL_3);
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_poly_root_finder.sv
// Directed bench for poly_root_finder: vector table of searches plus
// hand-written go-held and mid-search reset sequences.
module tb_poly_root_finder;

   logic       clk = 1'b0;
   logic       resetn;
   logic       go;
   logic [7:0] data_in;
   logic [7:0] data_result;
   logic       found;
   logic       done;
   logic       busy;
   logic [3:0] dbg_state;

   localparam logic [3:0] ST_LOAD_A = 4'd0;

   int n_checks = 0;
   int n_pass   = 0;

   poly_root_finder dut (
      .clk         (clk),
      .resetn      (resetn),
      .go          (go),
      .data_in     (data_in),
      .data_result (data_result),
      .found       (found),
      .done        (done),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a, b, c, y;
      logic       exp_found;
      logic [7:0] exp_result;
      int         exp_cycles;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // One press/release of go while presenting v; ends just after the release edge.
   task automatic load_val(input logic [7:0] v);
      @(negedge clk);
      data_in = v;
      go      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      go = 1'b1;
      @(posedge clk);
      @(negedge clk);
      go = 1'b0;
      @(posedge clk);
   endtask

   // Loads A,B,C,Y, then counts clock edges from EVAL_0 entry until done (bounded).
   task automatic run_search(input logic [7:0] a, b, c, y, input logic hold_go,
                             input string tag, output int cycles);
      load_val(a);
      load_val(b);
      load_val(c);
      load_val(y);
      @(negedge clk);
      if (hold_go) go = 1'b1;
      check({tag, " busy_at_eval0"}, busy, 1);
      check({tag, " cleared_found"}, found, 0);
      cycles = 0;
      while (!done && cycles < 1100) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end
   endtask

   // Acknowledge the result and return to LOAD_A; checks retention of the result.
   task automatic ack_result(input string tag, input logic exp_f, input logic [7:0] exp_r);
      @(negedge clk);
      go = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, " done_in_wait"}, done, 1);
      go = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({tag, " back_to_load_a"}, dbg_state, ST_LOAD_A);
      check({tag, " done_low"}, done, 0);
      check({tag, " found_retained"}, found, exp_f);
      check({tag, " result_retained"}, data_result, exp_r);
   endtask

   initial begin
      int cyc;
      string tag;

      vecs[0] = '{a: 8'd1, b: 8'd0, c: 8'd0,  y: 8'd9,  exp_found: 1'b1, exp_result: 8'd3,   exp_cycles: 16};
      vecs[1] = '{a: 8'd0, b: 8'd0, c: 8'd5,  y: 8'd5,  exp_found: 1'b1, exp_result: 8'd0,   exp_cycles: 4};
      vecs[2] = '{a: 8'd0, b: 8'd1, c: 8'd10, y: 8'd4,  exp_found: 1'b1, exp_result: 8'd250, exp_cycles: 1004};
      vecs[3] = '{a: 8'd0, b: 8'd0, c: 8'd5,  y: 8'd6,  exp_found: 1'b0, exp_result: 8'd0,   exp_cycles: 1024};
      vecs[4] = '{a: 8'd1, b: 8'd2, c: 8'd1,  y: 8'd16, exp_found: 1'b1, exp_result: 8'd3,   exp_cycles: 16};
      vecs[5] = '{a: 8'd1, b: 8'd0, c: 8'd0,  y: 8'd2,  exp_found: 1'b0, exp_result: 8'd0,   exp_cycles: 1024};

      // Clock/reset
      resetn  = 1'b0;
      go      = 1'b0;
      data_in = 8'd0;
      #1;
      check("reset state", dbg_state, ST_LOAD_A);
      check("reset result", data_result, 0);
      check("reset found", found, 0);
      check("reset done", done, 0);
      check("reset busy", busy, 0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < 6; i++) begin
         tag = $sformatf("vec%0d", i);
         run_search(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].y, 1'b0, tag, cyc);
         check({tag, " cycles"}, cyc, vecs[i].exp_cycles);
         check({tag, " done"}, done, 1);
         check({tag, " busy_off"}, busy, 0);
         check({tag, " found"}, found, vecs[i].exp_found);
         check({tag, " result"}, data_result, vecs[i].exp_result);
         ack_result(tag, vecs[i].exp_found, vecs[i].exp_result);
      end

      // go held high through the whole evaluation must not disturb it
      run_search(8'd2, 8'd3, 8'd1, 8'd15, 1'b1, "held_go", cyc);
      check("held_go cycles", cyc, 12);
      check("held_go found", found, 1);
      check("held_go result", data_result, 2);
      ack_result("held_go", 1'b1, 8'd2);

      // Asynchronous reset in the middle of a search
      load_val(8'd1);
      load_val(8'd0);
      load_val(8'd0);
      load_val(8'd200);
      repeat (6) @(negedge clk);
      check("mid busy before reset", busy, 1);
      #2 resetn = 1'b0;
      #1;
      check("async reset state", dbg_state, ST_LOAD_A);
      check("async reset busy", busy, 0);
      check("async reset done", done, 0);
      check("async reset found", found, 0);
      check("async reset result", data_result, 0);
      repeat (2) @(negedge clk);
      check("held reset state", dbg_state, ST_LOAD_A);
      resetn = 1'b1;
      run_search(8'd1, 8'd0, 8'd0, 8'd9, 1'b0, "post_reset", cyc);
      check("post_reset cycles", cyc, 16);
      check("post_reset found", found, 1);
      check("post_reset result", data_result, 3);
      ack_result("post_reset", 1'b1, 8'd3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
